// File: rtl/rs_ssc_dsd_pkg.sv
// Shared constants, FSM state type and GF(2^8) constant-multiply helpers
// for the SSC-DSD Reed-Solomon encoder.
package rs_ssc_dsd_pkg;

    // Low byte of the primitive polynomial x^8+x^6+x^4+x^3+x^2+x+1 (0x15F)
    localparam logic [7:0] GF_POLY    = 8'h5F;

    localparam int N_DATA_SYM = 36;
    localparam int N_CHK_SYM  = 3;
    localparam int SYM_W      = 8;
    localparam int DATA_W     = N_DATA_SYM * SYM_W;                 // 288
    localparam int CW_W       = (N_DATA_SYM + N_CHK_SYM) * SYM_W;   // 312

    // Largest alpha exponent ever requested: a^(2K) with K up to 36
    localparam int MAX_ALPHA_POW = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        OUT  = 2'd2
    } enc_state_t;

    // Single multiply by alpha: shift left, fold the overflow bit back in.
    function automatic logic [SYM_W-1:0] gf_mul_alpha(input logic [SYM_W-1:0] sym);
        logic [SYM_W-1:0] res;
        res = {sym[SYM_W-2:0], 1'b0};
        if (sym[SYM_W-1]) begin
            res = res ^ GF_POLY;
        end
        return res;
    endfunction

    // Multiply by a^k. k is always an elaboration-time constant at the call
    // sites, so this collapses to a fixed XOR network.
    function automatic logic [SYM_W-1:0] gf_mul_alpha_pow(input logic [SYM_W-1:0] sym,
                                                          input int               k);
        logic [SYM_W-1:0] res;
        res = sym;
        for (int n = 0; n < MAX_ALPHA_POW; n++) begin
            if (n < k) begin
                res = gf_mul_alpha(res);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_ssc_dsd_encoder_fold.sv
// One Horner step: folds K data symbols into the three check accumulators.
// Symbol j of the group sits at syms_i[(K-j)*8-1 -: 8], i.e. the lowest
// symbol index of the group is in the most significant byte.
module rs_ssc_dsd_fold
    import rs_ssc_dsd_pkg::*;
#(
    parameter int K = 4
) (
    input  logic [K*SYM_W-1:0] syms_i,
    input  logic [SYM_W-1:0]   acc0_i,
    input  logic [SYM_W-1:0]   acc1_i,
    input  logic [SYM_W-1:0]   acc2_i,
    output logic [SYM_W-1:0]   acc0_o,
    output logic [SYM_W-1:0]   acc1_o,
    output logic [SYM_W-1:0]   acc2_o
);

    logic [SYM_W-1:0] sym_w  [K];
    logic [SYM_W-1:0] term1_w[K];
    logic [SYM_W-1:0] term2_w[K];

    // Per-symbol weighting: a^j for P1 and a^(2j) for P2
    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_term
            assign sym_w[gi]   = syms_i[(K-gi)*SYM_W-1 -: SYM_W];
            assign term1_w[gi] = gf_mul_alpha_pow(sym_w[gi], gi);
            assign term2_w[gi] = gf_mul_alpha_pow(sym_w[gi], 2 * gi);
        end
    endgenerate

    // Shift the running sums by a^K / a^(2K) and add this group's terms
    always_comb begin
        acc0_o = acc0_i;
        acc1_o = gf_mul_alpha_pow(acc1_i, K);
        acc2_o = gf_mul_alpha_pow(acc2_i, 2 * K);
        for (int j = 0; j < K; j++) begin
            acc0_o = acc0_o ^ sym_w[j];
            acc1_o = acc1_o ^ term1_w[j];
            acc2_o = acc2_o ^ term2_w[j];
        end
    end

endmodule

// File: rtl/rs_ssc_dsd_encoder.sv
// Iterative systematic RS encoder producing the 39-symbol SSC-DSD codeword.
// Accepts one data word, folds SYMS_PER_CYCLE symbols per cycle from the
// highest group down to group 0, then holds the codeword until accepted.
module rs_ssc_dsd_encoder
    import rs_ssc_dsd_pkg::*;
#(
    parameter int SYMS_PER_CYCLE = 4   // must divide 36
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW_W-1:0]   codeword_out
);

    localparam int K     = SYMS_PER_CYCLE;
    localparam int NG    = N_DATA_SYM / K;
    localparam int GRP_W = (NG > 1) ? $clog2(NG) : 1;
    localparam int GRP_BITS = K * SYM_W;

    enc_state_t        state_q;
    logic [DATA_W-1:0] data_q;
    logic [GRP_W-1:0]  grp_q;
    logic [SYM_W-1:0]  acc0_q, acc1_q, acc2_q;
    logic [SYM_W-1:0]  acc0_d, acc1_d, acc2_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [CW_W-1:0]   cw_q;

    logic [GRP_BITS-1:0] grp_bank_w[NG];
    logic [GRP_BITS-1:0] grp_syms_w;

    // Slice the latched word into groups; group g holds symbols g*K..g*K+K-1
    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_bank
            assign grp_bank_w[gi] = data_q[DATA_W-1-gi*GRP_BITS -: GRP_BITS];
        end
    endgenerate

    // Select the group being folded this cycle
    always_comb begin
        grp_syms_w = grp_bank_w[grp_q];
    end

    rs_ssc_dsd_fold #(
        .K (K)
    ) u_fold (
        .syms_i (grp_syms_w),
        .acc0_i (acc0_q),
        .acc1_i (acc1_q),
        .acc2_i (acc2_q),
        .acc0_o (acc0_d),
        .acc1_o (acc1_d),
        .acc2_o (acc2_d)
    );

    // Control FSM with registered handshake outputs and codeword register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            grp_q       <= '0;
            acc0_q      <= '0;
            acc1_q      <= '0;
            acc2_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cw_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q     <= data_in;
                        acc0_q     <= '0;
                        acc1_q     <= '0;
                        acc2_q     <= '0;
                        grp_q      <= GRP_W'(NG - 1);
                        in_ready_q <= 1'b0;
                        state_q    <= ENC;
                    end
                end
                ENC: begin
                    acc0_q <= acc0_d;
                    acc1_q <= acc1_d;
                    acc2_q <= acc2_d;
                    if (grp_q == '0) begin
                        // Last group: publish straight from the fold outputs
                        cw_q        <= {data_q, acc0_d, acc1_d, acc2_d};
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else begin
                        grp_q <= grp_q - 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign codeword_out = cw_q;

endmodule

// File: doc/rs_ssc_dsd_encoder.md
# rs_ssc_dsd_encoder

Iterative systematic Reed-Solomon encoder over GF(2^8) producing the 39-symbol SSC-DSD codeword (36 data symbols + 3 check symbols) consumed by RS_SSC_DSD_DECODER. It sits on the write path ahead of the memory model. It accepts 288 data bits with a valid/ready handshake and computes the three check symbols over several cycles using Horner accumulation. It then holds the 312-bit codeword until the downstream stage accepts it.

## Interface
- SYMS_PER_CYCLE, default 4: data symbols folded per cycle; must divide 36 (1,2,3,4,6,9,12,18,36).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  data_in valid.
- in_ready  out  1  encoder can accept data.
- data_in  in  288  symbol i = data_in[287-8i -: 8], i = 0..35.
- out_valid  out  1  codeword_out valid.
- out_ready  in  1  downstream accepts codeword.
- codeword_out  out  312  {data[287:0], P0, P1, P2}; P0 = [23:16], P1 = [15:8], P2 = [7:0].

## Operation
- Field: primitive polynomial x^8+x^6+x^4+x^3+x^2+x+1 (0x15F); alpha = 0x02.
- Multiply by alpha: shift left 1; if the old bit 7 was set, XOR with 0x5F.
- Check symbols match the decoder H-matrix:
  - P0 = XOR over d_i.
  - P1 = sum over a^i·d_i.
  - P2 = sum over a^(2i)·d_i.
  - i = 0..35.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch data_in, clear accumulators, set grp=NG-1 where NG=36/SYMS_PER_CYCLE, go to ENC.
  - ENC: each cycle, fold group grp, covering symbols i = grp·K .. grp·K+K-1 with K=SYMS_PER_CYCLE:
    - acc0 ^= XOR d_i
    - acc1 = acc1·a^K ^ sum_j a^j·d_(grp·K+j)
    - acc2 = acc2·a^(2K) ^ sum_j a^(2j)·d_(grp·K+j)
    - When grp==0, load codeword_out and go to OUT; otherwise decrement grp.
  - OUT: out_valid=1, codeword_out stable. On out_ready, go to IDLE.
- Groups are processed from the highest index to the lowest, so Horner leaves exactly a^i on symbol i.
- in_ready is high only in IDLE. No back-to-back overlap; in_valid outside IDLE is ignored.
- Constant multipliers are pure XOR networks. No general GF multiplier is used.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, codeword_out=0, accumulators=0, grp=0.
- Latency: a handshake in cycle 0 gives out_valid in cycle NG+1. For K=4 that is cycle 10; for K=36 it is cycle 2.
- in_ready falls in the cycle after acceptance. It rises again the cycle after the out handshake, so throughput is one codeword per NG+2 cycles minimum.
- Backpressure: out_valid and codeword_out are held while out_ready=0, for any number of cycles.
- out_ready asserted with out_valid=0 has no effect.
- rst_n low in any state returns to the reset values immediately. Any in-flight word is discarded and never presented.
- Data bits pass through unmodified: codeword_out[311:24] equals the latched data_in.

## Structure
- Package rs_ssc_dsd_pkg holds:
  - GF_POLY = 8'h5F
  - N_DATA_SYM = 36, N_CHK_SYM = 3, SYM_W = 8
  - DATA_W = 288, CW_W = 312
  - enc_state_t {IDLE, ENC, OUT}
  - function gf_mul_alpha_pow(sym, k), a constant multiply by a^k built from repeated alpha steps.
- One sub-module, rs_ssc_dsd_fold: combinational. Inputs are K symbols plus acc0/acc1/acc2; outputs are the next accumulators.
- The top level keeps the FSM, group counter, data register and output register.

## Test plan
- All-zero data_in, out_ready=1: out_valid at cycle NG+1; codeword_out=0; in_ready high again one cycle after the out handshake.
- Symbol 0 = 0x01, rest 0: check bytes P0=01, P1=01, P2=01. Symbol 1 = 0x01 alone: P0=01, P1=02, P2=04.
- Symbol 8 = 0x01 alone: P1=5F (a^8), P2=86 (a^16). Symbol 7 = 0x02 alone: P0=02, P1=5F, P2=43 (a^15).
- Backpressure: hold out_ready=0 for 20 cycles. out_valid and codeword_out stay stable and in_valid pulses are ignored. One cycle of out_ready then returns to IDLE.
- Reset mid-ENC (rst_n low at cycle 3): out_valid=0, in_ready=1 immediately. The next word encodes correctly with no leftover accumulator state.
- 10k random words at SYMS_PER_CYCLE in {1,4,36}: feed RS_SSC_DSD_DECODER. Decode_result_out=00 and data_out equals data_in. Flip any single symbol: decoder returns 01 and the data is restored.
